// File: rtl/p_encoder_pkg.sv
// ---------------------------------------------------------------------------
// p_encoder_pkg
// Shared constants and types for the registered 4-to-2 priority encoder.
//   P_ENC_WIDTH : width of the request vector (4)
//   P_ENC_OUT_W : width of the encoded index (2)
//   p_enc_req_t : request vector type
//   p_enc_idx_t : encoded index type
// ---------------------------------------------------------------------------
package p_encoder_pkg;

    localparam int P_ENC_WIDTH = 4;
    localparam int P_ENC_OUT_W = 2;

    typedef logic [P_ENC_WIDTH-1:0] p_enc_req_t;
    typedef logic [P_ENC_OUT_W-1:0] p_enc_idx_t;

endpackage : p_encoder_pkg

// File: rtl/p_encoder_4to2_core.sv
// ---------------------------------------------------------------------------
// p_encoder_4to2_core
// Purely combinational priority logic. Bit WIDTH-1 has the highest priority.
// Ports:
//   Y     (in,  WIDTH bits) : request vector
//   index (out, OUT_W bits) : index of the highest set bit (0 when none set)
//   any   (out, 1 bit)      : at least one bit of Y is set
// ---------------------------------------------------------------------------
module p_encoder_4to2_core
    import p_encoder_pkg::*;
#(
    parameter int WIDTH = P_ENC_WIDTH,
    parameter int OUT_W = P_ENC_OUT_W
) (
    input  logic [WIDTH-1:0] Y,
    output logic [OUT_W-1:0] index,
    output logic             any
);

    // Walk the request vector from LSB to MSB; every set bit overwrites the
    // result, so the highest set bit is the one left standing at the end.
    // With no bit set the defaults give index 0 and any 0.
    always_comb begin
        index = '0;
        any   = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (Y[i]) begin
                index = OUT_W'(i);
                any   = 1'b1;
            end
        end
    end

endmodule : p_encoder_4to2_core

// File: rtl/p_encoder_4to2.sv
// ---------------------------------------------------------------------------
// p_encoder_4to2
// Registered 4-to-2 priority encoder: samples Y every rising edge and
// presents the index of its highest set bit on A one cycle later.
// Ports:
//   clk   (in,  1 bit)      : clock, rising edge active
//   rst   (in,  1 bit)      : asynchronous active-high reset, clears A/valid
//   Y     (in,  WIDTH bits) : request vector, bit 3 highest priority
//   A     (out, OUT_W bits) : registered index of the highest set bit
//   valid (out, 1 bit)      : registered OR-reduction of Y
// Build option:
//   P_ENCODER_4TO2_HOLD_EN : when defined, an all-zero Y keeps the previous
//                            A (valid still drops to 0); otherwise A -> 00.
// ---------------------------------------------------------------------------
module p_encoder_4to2
    import p_encoder_pkg::*;
#(
    parameter int WIDTH = P_ENC_WIDTH,
    parameter int OUT_W = P_ENC_OUT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] Y,
    output logic [OUT_W-1:0] A,
    output logic             valid
);

    // Only the 4-bit/2-bit configuration is implemented; reject anything else
    // at elaboration rather than silently building a mismatched encoder.
    if (WIDTH != 4) begin : g_bad_width
        $error("p_encoder_4to2: WIDTH must be 4, got %0d", WIDTH);
    end
    if (OUT_W != $clog2(WIDTH)) begin : g_bad_out_w
        $error("p_encoder_4to2: OUT_W must be $clog2(WIDTH), got %0d", OUT_W);
    end

    logic [OUT_W-1:0] core_index;
    logic             core_any;
    logic [OUT_W-1:0] next_a;

    p_encoder_4to2_core #(
        .WIDTH (WIDTH),
        .OUT_W (OUT_W)
    ) u_core (
        .Y     (Y),
        .index (core_index),
        .any   (core_any)
    );

    // Choose what A loads on the next edge. The core already yields 00 for
    // an all-zero request, so the default build passes it straight through;
    // the hold build recirculates the current A when nothing is requested.
`ifdef P_ENCODER_4TO2_HOLD_EN
    always_comb begin
        next_a = core_any ? core_index : A;
    end
`else
    always_comb begin
        next_a = core_index;
    end
`endif

    // Output register. Reset clears both outputs immediately and keeps them
    // clear while held, which also discards whatever result was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A     <= '0;
            valid <= 1'b0;
        end else begin
            A     <= next_a;
            valid <= core_any;
        end
    end

endmodule : p_encoder_4to2

// File: tb/tb_p_encoder_4to2.sv
// ---------------------------------------------------------------------------
// tb_p_encoder_4to2
// Directed self-checking bench for p_encoder_4to2. Honors the
// P_ENCODER_4TO2_HOLD_EN build option for the zero-request expectations.
// ---------------------------------------------------------------------------
module tb_p_encoder_4to2;

`ifdef P_ENCODER_4TO2_HOLD_EN
    localparam bit HOLD = 1'b1;
`else
    localparam bit HOLD = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] Y;
    logic [1:0] A;
    logic       valid;

    int checks = 0;
    int errors = 0;

    // Model of the last registered A, used for the hold behaviour in the sweep
    logic [1:0] model_a;

    p_encoder_4to2 dut (
        .clk   (clk),
        .rst   (rst),
        .Y     (Y),
        .A     (A),
        .valid (valid)
    );

    // Free-running clock, first rising edge at 5
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference priority function written as an explicit case table
    function automatic logic [1:0] refEnc(input logic [3:0] v);
        casez (v)
            4'b1???: return 2'b11;
            4'b01??: return 2'b10;
            4'b001?: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Drive a new request away from the rising edge, then wait until just
    // after the next rising edge so the registered result can be sampled
    task automatic applyStimulus(input logic [3:0] v);
        @(negedge clk);
        Y = v;
        @(posedge clk);
        #1;
    endtask

    // Compare both outputs against the expected values
    task automatic checkOutput(input string tag, input logic [1:0] exp_a,
                               input logic exp_valid);
        checks++;
        assert (A === exp_a) else begin
            errors++;
            $error("[TB] FAIL %s.A observed=%b expected=%b", tag, A, exp_a);
        end
        checks++;
        assert (valid === exp_valid) else begin
            errors++;
            $error("[TB] FAIL %s.valid observed=%b expected=%b", tag, valid, exp_valid);
        end
    endtask

    initial begin
        logic [3:0] v;
        logic [1:0] exp_a;

        rst = 1'b0;
        Y   = 4'b0000;

        // Reset asserted before any clock edge must clear outputs at once
        #2;
        Y   = 4'b1111;
        rst = 1'b1;
        #1;
        checkOutput("reset_async", 2'b00, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("reset_held", 2'b00, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_release", 2'b11, 1'b1);

        // Ascending sweep, one value per cycle
        applyStimulus(4'b0001); checkOutput("sweep_0001", 2'b00, 1'b1);
        applyStimulus(4'b0011); checkOutput("sweep_0011", 2'b01, 1'b1);
        applyStimulus(4'b0111); checkOutput("sweep_0111", 2'b10, 1'b1);
        applyStimulus(4'b1111); checkOutput("sweep_1111", 2'b11, 1'b1);

        // Lower bits are ignored once a higher bit is set
        applyStimulus(4'b1010); checkOutput("dc_1010", 2'b11, 1'b1);
        applyStimulus(4'b0110); checkOutput("dc_0110", 2'b10, 1'b1);
        applyStimulus(4'b0101); checkOutput("dc_0101", 2'b10, 1'b1);

        // All 16 patterns against the reference function
        model_a = 2'b10;
        for (int i = 0; i < 16; i++) begin
            v = 4'(i);
            if (v == 4'b0000)
                exp_a = HOLD ? model_a : 2'b00;
            else
                exp_a = refEnc(v);
            applyStimulus(v);
            checkOutput($sformatf("all_%b", v), exp_a, |v);
            model_a = exp_a;
        end

        // Zero request after a nonzero one
        applyStimulus(4'b0100); checkOutput("zero_pre", 2'b10, 1'b1);
        applyStimulus(4'b0000); checkOutput("zero_in", HOLD ? 2'b10 : 2'b00, 1'b0);

        // Mid-stream reset between two edges
        applyStimulus(4'b1000); checkOutput("mid_1000", 2'b11, 1'b1);
        @(negedge clk);
        Y = 4'b0010;
        #1;
        rst = 1'b1;
        #1;
        checkOutput("mid_reset_async", 2'b00, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("mid_after_release", 2'b01, 1'b1);

        // After a reset the retained value for a zero request is 00
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("rst2_async", 2'b00, 1'b0);
        rst = 1'b0;
        Y   = 4'b0000;
        @(posedge clk);
        #1;
        checkOutput("rst2_zero", 2'b00, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_p_encoder_4to2

// File: doc/p_encoder_4to2.md
# p_encoder_4to2

Registered 4-to-2 priority encoder. It samples a 4-bit request vector `Y` and outputs the 2-bit index of the highest-numbered asserted bit on `A`, together with a `valid` flag. It sits as a small arbitration or index-extraction leaf wherever a one-of-N highest-priority index is needed one cycle later.

## Interface
- `WIDTH`, default 4: request vector width. Only 4 is supported; an elaboration-time check rejects other values.
- `OUT_W`, default 2: index width. Equals `$clog2(WIDTH)`; an elaboration-time check rejects other values.
- `clk` input, 1 bit: single clock. All state updates on the rising edge.
- `rst` input, 1 bit: asynchronous, active-high reset.
- `Y` input, `WIDTH` bits: request vector. Bit 3 has the highest priority and bit 0 the lowest.
- `A` output, `OUT_W` bits: encoded index of the highest set bit of `Y`.
- `valid` output, 1 bit: 1 when the sampled `Y` had at least one bit set.

## Operation
- Combinational priority function on `Y`:
  - `Y[3]` set gives 11.
  - Otherwise `Y[2]` set gives 10.
  - Otherwise `Y[1]` set gives 01.
  - Otherwise `Y[0]` set gives 00.
- Lower bits are don't-care once a higher bit is set. For example 0011 gives 01, 0111 gives 10, 1111 gives 11, and 0001 gives 00.
- `Y` = 0000, without the hold feature (see Configuration): the encoded value is 00 and `valid` = 0.
- `valid` is the OR-reduction of `Y`, registered alongside `A`.
- No handshake. `Y` is sampled on every rising edge.
- `A` and `valid` are always registered; there is no combinational path from `Y` to the outputs.

## Timing
- Latency: exactly 1 cycle. `Y` present before rising edge n appears on `A` and `valid` after edge n.
- Reset:
  - `rst` high drives `A` = 00 and `valid` = 0 immediately, without waiting for a clock edge.
  - The outputs hold those values while `rst` is high.
  - On the first rising edge after `rst` deasserts, the current `Y` is sampled.
- Reset mid-operation: any in-flight result is discarded. No stale value reappears after release.
- `Y` changing every cycle: each cycle's result appears in order, one cycle later, with no skipped or merged results.
- The outputs are glitch-free between edges because they are pure flop outputs.

## Configuration
- Macro: `P_ENCODER_4TO2_HOLD_EN`.
- When defined and the sampled `Y` = 0000:
  - `A` retains its previous registered value.
  - `valid` = 0.
  - After reset, the retained value is 00.
- When not defined, `Y` = 0000 gives `A` = 00 and `valid` = 0.
- Nonzero `Y` behaves identically in both builds.

## Structure
- Package `p_encoder_pkg` holds:
  - `P_ENC_WIDTH` = 4 and `P_ENC_OUT_W` = 2.
  - A typedef for the request vector.
  - A typedef for the index.
- Sub-module `p_encoder_4to2_core`:
  - Purely combinational priority logic, `Y` in, index and any-bit-set out.
  - Implemented as a loop from LSB to MSB so that the last (highest) set bit wins.
- The top level contains:
  - One instance of `p_encoder_4to2_core`.
  - The output register with asynchronous reset.
  - The hold mux under `P_ENCODER_4TO2_HOLD_EN`.
  - Parameter legality checks.

## Test plan
- Reset: assert `rst` with `Y` = 1111 and no clock edge -> `A` = 00 and `valid` = 0 immediately. Release `rst` and clock once -> `A` = 11, `valid` = 1.
- Ascending sweep, one value per cycle: `Y` = 0001, 0011, 0111, 1111 -> `A` = 00, 01, 10, 11 on the following cycles, with `valid` = 1 throughout.
- Don't-care lower bits: `Y` = 1010 -> `A` = 11. `Y` = 0110 -> `A` = 10. `Y` = 0101 -> `A` = 10.
- All 16 patterns: compare against a reference model at 1-cycle latency, checking both `A` and `valid`.
- Zero input: `Y` = 0100 then 0000.
  - Without `P_ENCODER_4TO2_HOLD_EN`: `A` = 10 then 00.
  - With `P_ENCODER_4TO2_HOLD_EN`: `A` = 10 then 10.
  - `valid` = 1 then 0 in both builds.
- Mid-stream reset: stream `Y` = 1000, 0010, pulse `rst` between the two edges -> outputs clear at once. The next edge after release shows the value for the `Y` applied at that edge, not the pre-reset value.
